// File: rtl/instruction_memory_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader_pkg
// Description : Shared types and constants for the instruction memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_memory_loader_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;
    localparam int MAX_WORDS   = 64;
    localparam int INDEX_W     = 6;

    // Largest count byte that still describes a loadable program
    localparam logic [7:0] MAX_COUNT = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } load_state_t;

    // Places one byte into lane idx of a little-endian word
    function automatic logic [IMEM_DATA_W-1:0] insert_byte(
        input logic [IMEM_DATA_W-1:0] word,
        input logic [1:0]             idx,
        input logic [7:0]             data
    );
        logic [IMEM_DATA_W-1:0] result;
        result = word;
        case (idx)
            2'd0:    result[7:0]   = data;
            2'd1:    result[15:8]  = data;
            2'd2:    result[23:16] = data;
            default: result[31:24] = data;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_memory_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : imem_word_assembler
// Description : Collects four bytes, least significant first, into a 32-bit
//               instruction word and flags the cycle the fourth byte arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_word_assembler
    import instruction_memory_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [IMEM_DATA_W-1:0] word_next,
    output logic                   complete
);

    logic [IMEM_DATA_W-1:0] word_q;
    logic [1:0]             byte_idx;

    // The word including the byte being accepted now, so the writer can
    // register it on the same edge as the fourth byte
    assign word_next = insert_byte(word_q, byte_idx, byte_in);
    assign complete  = shift_en && (byte_idx == 2'd3);

    // Byte lane counter wraps after the fourth byte, ready for the next word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            byte_idx <= 2'd0;
        end else if (clear) begin
            word_q   <= '0;
            byte_idx <= 2'd0;
        end else if (shift_en) begin
            word_q   <= word_next;
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader
// Description : Receives a framed byte stream (count byte N, then 4*N data
//               bytes LSB first), writes the assembled words to consecutive
//               word addresses of the instruction memory and holds the CPU
//               while the program is incomplete.
//               Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
//               checksum byte that is verified before the load completes.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [IMEM_ADDR_W-1:0] WA,
    output logic [IMEM_DATA_W-1:0] WD,
    output logic                   WE,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    load_state_t            state;
    logic [7:0]             n_words;
    logic [INDEX_W-1:0]     word_idx;
    logic                   accept;
    logic                   count_accept;
    logic                   load_accept;
    logic                   last_word;
    logic [IMEM_DATA_W-1:0] word_next;
    logic                   word_complete;

    assign accept       = rx_valid && rx_ready;
    assign count_accept = accept && (state == ST_IDLE);
    assign load_accept  = accept && (state == ST_LOAD);
    assign last_word    = (8'(word_idx) == (n_words - 8'd1));

    imem_word_assembler u_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (count_accept),
        .shift_en  (load_accept),
        .byte_in   (rx_data),
        .word_next (word_next),
        .complete  (word_complete)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of the data bytes of the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (count_accept) begin
            csum <= 8'h00;
        end else if (load_accept) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    // Frame sequencer; every output is registered so rx_ready/WE/done line
    // up with the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rx_ready <= 1'b0;
            WA       <= '0;
            WD       <= '0;
            WE       <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            n_words  <= 8'd0;
            word_idx <= '0;
        end else begin
            WE   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        if (rx_data > MAX_COUNT) begin
                            // Oversize program: flag it and keep waiting
                            err <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            n_words  <= rx_data;
                            word_idx <= '0;
                            if (rx_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= ST_CHECK;
                                cpu_hold <= 1'b1;
`else
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                rx_ready <= 1'b0;
                                cpu_hold <= 1'b0;
`endif
                            end else begin
                                state    <= ST_LOAD;
                                cpu_hold <= 1'b1;
                            end
                        end
                    end
                end

                ST_LOAD: begin
                    rx_ready <= 1'b1;
                    if (word_complete) begin
                        state    <= ST_WRITE;
                        rx_ready <= 1'b0;
                        WE       <= 1'b1;
                        WA       <= {word_idx, 2'b00};
                        WD       <= word_next;
                    end
                end

                ST_WRITE: begin
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= ST_CHECK;
                        rx_ready <= 1'b1;
`else
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        rx_ready <= 1'b0;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        word_idx <= word_idx + INDEX_W'(1);
                        state    <= ST_LOAD;
                        rx_ready <= 1'b1;
                    end
                end

                ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    rx_ready <= 1'b1;
                    if (accept) begin
                        if (rx_data != csum) begin
                            err <= 1'b1;
                        end
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        rx_ready <= 1'b0;
                        cpu_hold <= 1'b0;
                    end
`else
                    state    <= ST_IDLE;
                    rx_ready <= 1'b1;
`endif
                end

                ST_DONE: begin
                    state    <= ST_IDLE;
                    rx_ready <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    rx_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
